// File: rtl/forward_hazard_unit_pkg.sv
// Shared types for the forwarding / load-use hazard unit:
// operand-select encoding and the pipeline tracking record.
package forward_hazard_unit_pkg;

    // Tracking records carry rd zero-extended to this width (REG_AW <= 8).
    localparam int STG_AW = 8;

    typedef enum logic [1:0] {
        SEL_RF   = 2'd0,
        SEL_EX   = 2'd1,
        SEL_MEM  = 2'd2,
        SEL_ZERO = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [STG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stg_t;

    function automatic logic stg_hits(stg_t s, logic [STG_AW-1:0] a);
        return s.valid & s.regwrite & (s.rd == a);
    endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline tracking stage (EX or MEM) of the hazard unit.
// A bubble loads the record with its valid bit cleared.
module fwd_stage_reg
    import forward_hazard_unit_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bubble,
    input  stg_t d,
    output stg_t q
);

    stg_t stg_d, stg_q;

    always_comb begin
        stg_d = d;
        if (bubble) stg_d.valid = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) stg_q <= '0;
        else       stg_q <= stg_d;
    end

    assign q = stg_q;

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding and load-use stall detection for EX/MEM stages.
// Define FWD_HAZARD_STATS_EN to add the stall_cnt / fwd_cnt outputs.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int ZERO_REG = 31
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_memread,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_used,
    input  logic [NUM_SRC*DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0]         ex_result,
    input  logic [DATA_W-1:0]         mem_result,
    output logic [NUM_SRC*DATA_W-1:0] fwd_data,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               fwd_cnt
`endif
);

    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

    stg_t id_s, ex_q, mem_q;

    always_comb begin
        id_s          = '0;
        id_s.valid    = id_valid;
        id_s.rd       = STG_AW'(id_rd);
        id_s.regwrite = id_regwrite;
        id_s.memread  = id_memread;
    end

    fwd_stage_reg u_ex (
        .clk    (clk),
        .reset  (reset),
        .bubble (stall),
        .d      (id_s),
        .q      (ex_q)
    );

    fwd_stage_reg u_mem (
        .clk    (clk),
        .reset  (reset),
        .bubble (1'b0),
        .d      (ex_q),
        .q      (mem_q)
    );

    logic [REG_AW-1:0] src;
    logic              ex_hit;
    logic              mem_hit;
    fwd_sel_e          sel;

    always_comb begin
        stall    = 1'b0;
        fwd_sel  = '0;
        fwd_data = '0;
        src      = '0;
        ex_hit   = 1'b0;
        mem_hit  = 1'b0;
        sel      = SEL_RF;
        for (int i = 0; i < NUM_SRC; i++) begin
            src     = src_addr[i*REG_AW +: REG_AW];
            ex_hit  = stg_hits(ex_q, STG_AW'(src)) && (src != ZR);
            mem_hit = stg_hits(mem_q, STG_AW'(src)) && (src != ZR);
            // A load in EX has no data yet: never select it, stall instead.
            if (src == ZR)                     sel = SEL_ZERO;
            else if (ex_hit && !ex_q.memread)  sel = SEL_EX;
            else if (mem_hit)                  sel = SEL_MEM;
            else                               sel = SEL_RF;
            fwd_sel[i*2 +: 2] = sel;
            unique case (sel)
                SEL_ZERO: fwd_data[i*DATA_W +: DATA_W] = '0;
                SEL_EX:   fwd_data[i*DATA_W +: DATA_W] = ex_result;
                SEL_MEM:  fwd_data[i*DATA_W +: DATA_W] = mem_result;
                default:  fwd_data[i*DATA_W +: DATA_W] =
                              rf_data[i*DATA_W +: DATA_W];
            endcase
            if (id_valid && src_used[i] && ex_hit && ex_q.memread)
                stall = 1'b1;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic        any_fwd;
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] fwd_cnt_d, fwd_cnt_q;

    always_comb begin
        any_fwd = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_used[i] &&
                (fwd_sel[i*2 +: 2] == SEL_EX ||
                 fwd_sel[i*2 +: 2] == SEL_MEM))
                any_fwd = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (any_fwd && fwd_cnt_q != '1)
            fwd_cnt_d = fwd_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed + randomized bench for forward_hazard_unit against an
// instruction-history reference model.
module tb_forward_hazard_unit;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int ZR = 31;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [AW-1:0]    id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic [NS*AW-1:0] src_addr;
    logic [NS-1:0]    src_used;
    logic [NS*DW-1:0] rf_data;
    logic [DW-1:0]    ex_result;
    logic [DW-1:0]    mem_result;
    logic [NS*DW-1:0] fwd_data;
    logic [NS*2-1:0]  fwd_sel;
    logic             stall;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0]      stall_cnt;
    logic [31:0]      fwd_cnt;
`endif

    always #5 clk = ~clk;

    forward_hazard_unit #(
        .DATA_W   (DW),
        .REG_AW   (AW),
        .NUM_SRC  (NS),
        .ZERO_REG (ZR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .src_addr    (src_addr),
        .src_used    (src_used),
        .rf_data     (rf_data),
        .ex_result   (ex_result),
        .mem_result  (mem_result),
        .fwd_data    (fwd_data),
        .fwd_sel     (fwd_sel),
        .stall       (stall)
`ifdef FWD_HAZARD_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .fwd_cnt     (fwd_cnt)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: the two most recent issued instructions (youngest first).
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } rec_t;

    rec_t        m_ex;
    rec_t        m_mem;
    int unsigned m_stall_cnt;
    int unsigned m_fwd_cnt;
    bit          m_stall;
    bit          m_any;

    function automatic bit m_hit(rec_t r, int a);
        return r.v && r.rw && (r.rd == a) && (a != ZR);
    endfunction

    task automatic step();
        int          a;
        int          es;
        logic [63:0] ed;
        #1;
        m_stall = 0;
        m_any   = 0;
        for (int i = 0; i < NS; i++) begin
            a = int'(src_addr[i*AW +: AW]);
            if (a == ZR) begin
                es = 3; ed = 64'd0;
            end else if (m_hit(m_ex, a) && !m_ex.mr) begin
                es = 1; ed = ex_result;
            end else if (m_hit(m_mem, a)) begin
                es = 2; ed = mem_result;
            end else begin
                es = 0; ed = rf_data[i*DW +: DW];
            end
            if (id_valid && src_used[i] && m_hit(m_ex, a) && m_ex.mr)
                m_stall = 1;
            if (src_used[i] && (es == 1 || es == 2))
                m_any = 1;
            chk($sformatf("sel%0d", i), 64'(fwd_sel[i*2 +: 2]), 64'(es));
            chk($sformatf("data%0d", i), fwd_data[i*DW +: DW], ed);
        end
        chk("stall", 64'(stall), 64'(m_stall));
`ifdef FWD_HAZARD_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall_cnt));
        chk("fwd_cnt", 64'(fwd_cnt), 64'(m_fwd_cnt));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_ex.v      = 0;
            m_mem.v     = 0;
            m_stall_cnt = 0;
            m_fwd_cnt   = 0;
        end else begin
            m_mem = m_ex;
            if (m_stall) begin
                m_ex.v = 0;
            end else begin
                m_ex.v  = id_valid;
                m_ex.rd = int'(id_rd);
                m_ex.rw = id_regwrite;
                m_ex.mr = id_memread;
            end
            if (m_stall && m_stall_cnt != 32'hffff_ffff) m_stall_cnt++;
            if (m_any && m_fwd_cnt != 32'hffff_ffff) m_fwd_cnt++;
        end
        m_stall = 0;
        m_any   = 0;
        #1;
    endtask

    task automatic set_id(bit v, int rd, bit rw, bit mr);
        id_valid    = v;
        id_rd       = AW'(rd);
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic set_src(int a0, bit u0, int a1, bit u1);
        src_addr = {AW'(a1), AW'(a0)};
        src_used = {u1, u0};
    endtask

    task automatic rnd_data();
        rf_data    = {$urandom, $urandom, $urandom, $urandom};
        ex_result  = {$urandom, $urandom};
        mem_result = {$urandom, $urandom};
    endtask

    function automatic int rnd_reg();
        int r;
        r = int'($urandom_range(0, 8));
        return (r == 8) ? ZR : r;
    endfunction

    initial begin
        m_ex        = '{0, 0, 0, 0};
        m_mem       = '{0, 0, 0, 0};
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
        m_stall     = 0;
        m_any       = 0;
        reset = 1'b1;
        set_id(0, 0, 0, 0);
        set_src(0, 1, ZR, 1);
        rnd_data();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        step();
        chk("rst_sel0", 64'(fwd_sel[1:0]), 64'd0);
        chk("rst_sel1", 64'(fwd_sel[3:2]), 64'd3);
        chk("rst_stall", 64'(stall), 64'd0);
        tick();

        // EX forwarding
        set_id(1, 2, 1, 0); set_src(7, 0, 8, 0); step(); tick();
        set_id(1, 3, 1, 0); set_src(2, 1, 0, 1); ex_result = 64'd24;
        step();
        chk("ex_sel", 64'(fwd_sel[1:0]), 64'd1);
        chk("ex_data", fwd_data[63:0], 64'd24);
        chk("ex_stall", 64'(stall), 64'd0);
        tick();

        // MEM forwarding
        set_id(1, 2, 1, 0); set_src(9, 0, 9, 0); step(); tick();
        set_id(1, 7, 1, 0); step(); tick();
        set_id(1, 8, 1, 0); set_src(2, 1, 1, 0); mem_result = 64'd64;
        step();
        chk("mem_sel", 64'(fwd_sel[1:0]), 64'd2);
        chk("mem_data", fwd_data[63:0], 64'd64);
        tick();

        // Double hit: youngest writer wins
        set_id(1, 4, 1, 0); set_src(9, 0, 9, 0); step(); tick();
        set_id(1, 4, 1, 0); step(); tick();
        set_id(1, 10, 1, 0); set_src(4, 1, 4, 1);
        ex_result = 64'd34; mem_result = 64'd100;
        step();
        chk("dbl_data0", fwd_data[63:0], 64'd34);
        chk("dbl_data1", fwd_data[127:64], 64'd34);
        tick();

        // Load-use
        reset = 1'b1; set_id(0, 0, 0, 0); tick(); reset = 1'b0;
        set_id(1, 5, 1, 1); set_src(9, 0, 9, 0); step(); tick();
        set_id(1, 9, 1, 0); set_src(5, 1, 1, 1); step();
        chk("lu_stall", 64'(stall), 64'd1);
        tick();
        step();
        chk("lu_stall_end", 64'(stall), 64'd0);
        chk("lu_sel", 64'(fwd_sel[1:0]), 64'd2);
`ifdef FWD_HAZARD_STATS_EN
        chk("lu_cnt", 64'(stall_cnt), 64'd1);
`endif
        tick();

        // Zero register and disabled writer
        set_id(1, ZR, 1, 0); set_src(9, 0, 9, 0); step(); tick();
        set_id(1, 2, 0, 0); step(); tick();
        set_id(1, 11, 1, 0); set_src(ZR, 1, 2, 1); step();
        chk("zr_data0", fwd_data[63:0], 64'd0);
        chk("zr_data1", fwd_data[127:64], rf_data[127:64]);
        chk("zr_stall", 64'(stall), 64'd0);
        tick();

        // Reset mid-operation
        set_id(1, 6, 1, 0); set_src(9, 0, 9, 0); step(); tick();
        reset = 1'b1; set_id(0, 0, 0, 0); tick(); reset = 1'b0;
        set_id(1, 12, 1, 0); set_src(6, 1, 6, 1); step();
        chk("rst_mid_sel", 64'(fwd_sel[1:0]), 64'd0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            set_id($urandom_range(0, 3) != 0, rnd_reg(),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            set_src(rnd_reg(), 1'($urandom), rnd_reg(), 1'($urandom));
            rnd_data();
            step();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
